// File: rtl/pwm_hbridge_multi.sv
// Multi-channel signed-duty PWM for H-bridge drivers: shared period counter,
// period-aligned shadow duties, dead time on reversal, brake, period strobe.
module pwm_hbridge_multi #(
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 12,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS*16-1:0]  duty,
  input  logic                    update_en,
  input  logic                    brake,
  output logic [CHANNELS-1:0]     pwm_out,
  output logic [CHANNELS-1:0]     dir_a,
  output logic [CHANNELS-1:0]     dir_b,
  output logic                    period_start,
  output logic [2*CHANNELS-1:0]   state_dbg
);

  localparam int HALF      = 1 << (CNT_WIDTH - 1);
  localparam int MAX_COUNT = 1 << CNT_WIDTH;
  localparam int DW        = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

  localparam logic [CNT_WIDTH-1:0] HALF_V   = CNT_WIDTH'(HALF);
  localparam logic [CNT_WIDTH-2:0] CNT_LAST = '1;
  localparam logic [DW-1:0]        DEAD_V   = DW'(DEAD_CYCLES);

  typedef enum logic [1:0] {IDLE, DEAD, DRIVE_A, DRIVE_B} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_A, DIR_B} dir_t;

  logic                 run;
  logic [CNT_WIDTH-2:0] cnt;
  logic [CNT_WIDTH-2:0] cnt_next;
  logic                 boundary;

  state_t               state    [CHANNELS];
  dir_t                 last_dir [CHANNELS];
  dir_t                 pend_dir [CHANNELS];
  logic [DW-1:0]        dead_cnt [CHANNELS];
  logic [CNT_WIDTH-1:0] mag      [CHANNELS];
  logic [CNT_WIDTH-1:0] shadow   [CHANNELS];

  logic [CNT_WIDTH-1:0] clamped  [CHANNELS];
  logic [CNT_WIDTH-1:0] sel      [CHANNELS];
  logic [CNT_WIDTH-1:0] dec_mag  [CHANNELS];
  dir_t                 dec_dir  [CHANNELS];

  // The first edge after reset release acts as a boundary so the first
  // visible cycle is cnt = 0 with period_start high.
  always_comb begin
    boundary = !run || (cnt == CNT_LAST);
    cnt_next = boundary ? '0 : cnt + 1'b1;
  end

  // Decode uses the value that the shadow register holds after this edge.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clamped[i] = CNT_WIDTH'(duty[16*i +: 16]);
      if ({16'b0, duty[16*i +: 16]} > 32'(MAX_COUNT - 1))
        clamped[i] = '1;
      sel[i] = (boundary && update_en) ? clamped[i] : shadow[i];
      if (sel[i] > HALF_V) begin
        dec_dir[i] = DIR_A;
        dec_mag[i] = sel[i] - HALF_V;
      end else if (sel[i] < HALF_V) begin
        dec_dir[i] = DIR_B;
        dec_mag[i] = HALF_V - sel[i];
      end else begin
        dec_dir[i] = DIR_NONE;
        dec_mag[i] = '0;
      end
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < CHANNELS; i++)
      state_dbg[2*i +: 2] = state[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run          <= 1'b0;
      cnt          <= '0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      dir_a        <= '0;
      dir_b        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]    <= IDLE;
        last_dir[i] <= DIR_NONE;
        pend_dir[i] <= DIR_NONE;
        dead_cnt[i] <= '0;
        mag[i]      <= '0;
        shadow[i]   <= HALF_V;
      end
    end else begin
      run          <= 1'b1;
      cnt          <= cnt_next;
      period_start <= boundary;
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary && update_en)
          shadow[i] <= clamped[i];

        if (brake) begin
          state[i]   <= IDLE;
          pwm_out[i] <= 1'b0;
          dir_a[i]   <= 1'b0;
          dir_b[i]   <= 1'b0;
        end else if (boundary) begin
          mag[i] <= dec_mag[i];
          if (dec_dir[i] == DIR_NONE) begin
            state[i]   <= IDLE;
            pwm_out[i] <= 1'b0;
            dir_a[i]   <= 1'b0;
            dir_b[i]   <= 1'b0;
          end else if (last_dir[i] == DIR_NONE || last_dir[i] == dec_dir[i] ||
                       DEAD_CYCLES == 0) begin
            state[i]    <= (dec_dir[i] == DIR_A) ? DRIVE_A : DRIVE_B;
            last_dir[i] <= dec_dir[i];
            dir_a[i]    <= (dec_dir[i] == DIR_A);
            dir_b[i]    <= (dec_dir[i] == DIR_B);
            pwm_out[i]  <= ({1'b0, cnt_next} < dec_mag[i]);
          end else begin
            // Reversal: both legs off for DEAD_CYCLES cycles first.
            state[i]    <= DEAD;
            pend_dir[i] <= dec_dir[i];
            dead_cnt[i] <= DEAD_V;
            pwm_out[i]  <= 1'b0;
            dir_a[i]    <= 1'b0;
            dir_b[i]    <= 1'b0;
          end
        end else begin
          case (state[i])
            DEAD: begin
              if (dead_cnt[i] <= DW'(1)) begin
                state[i]    <= (pend_dir[i] == DIR_A) ? DRIVE_A : DRIVE_B;
                last_dir[i] <= pend_dir[i];
                dir_a[i]    <= (pend_dir[i] == DIR_A);
                dir_b[i]    <= (pend_dir[i] == DIR_B);
                pwm_out[i]  <= ({1'b0, cnt_next} < mag[i]);
              end else begin
                dead_cnt[i] <= dead_cnt[i] - DW'(1);
              end
            end
            DRIVE_A, DRIVE_B: pwm_out[i] <= ({1'b0, cnt_next} < mag[i]);
            default: begin
              pwm_out[i] <= 1'b0;
              dir_a[i]   <= 1'b0;
              dir_b[i]   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
